// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
// Tracks how many cars are parked and sequences the entry and exit barriers.
// It consumes the one-cycle entry/exit strobes from the sensor edge detectors.
// Each barrier is a CLOSED/OPEN machine with a down-counter hold timer.
// An accepted car arriving while the barrier is already open reloads its timer.
// An entry is refused when the lot is full, unless a valid exit frees a space
// in the same cycle. An exit seen while the lot is empty is flagged and ignored.
module parking_gate_ctrl #(
  parameter int CAPACITY    = 8,
  parameter int OPEN_CYCLES = 100
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           entry_pulse,
  input  logic                           exit_pulse,
  output logic [$clog2(CAPACITY+1)-1:0]  count,
  output logic                           full,
  output logic                           empty,
  output logic                           entry_gate_open,
  output logic                           exit_gate_open,
  output logic                           entry_denied,
  output logic                           exit_error
);

  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int TMR_W = $clog2(OPEN_CYCLES + 1);

  localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] RELOAD_V = TMR_W'(OPEN_CYCLES - 1);

  // Gate index 0 is the entry barrier, index 1 is the exit barrier.
  localparam int NUM_GATES = 2;

  typedef enum logic {
    GATE_CLOSED = 1'b0,
    GATE_OPEN   = 1'b1
  } gate_state_e;

  logic [CNT_W-1:0]     count_q, count_d;
  logic                 entry_denied_q, entry_denied_d;
  logic                 exit_error_q, exit_error_d;
  logic                 entry_ok, exit_ok;
  logic [NUM_GATES-1:0] gate_accept;
  logic [NUM_GATES-1:0] gate_open;

  // Acceptance is judged on the registered count.
  // An exit is checked first because a same-cycle valid exit frees a space for an entry.
  always_comb begin
    exit_ok  = exit_pulse && (count_q != '0);
    entry_ok = entry_pulse && ((count_q < CAP_V) || exit_ok);
  end

  // Next occupancy and one-cycle flags.
  // A simultaneous entry and exit leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (entry_ok && !exit_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (exit_ok && !entry_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    entry_denied_d = entry_pulse && !entry_ok;
    exit_error_d   = exit_pulse && (count_q == '0);
  end

  // Occupancy and flag registers.
  // Reset is asynchronous so that a reset clears the lot immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q        <= '0;
      entry_denied_q <= 1'b0;
      exit_error_q   <= 1'b0;
    end else begin
      count_q        <= count_d;
      entry_denied_q <= entry_denied_d;
      exit_error_q   <= exit_error_d;
    end
  end

  assign gate_accept = {exit_ok, entry_ok};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GATES; gi++) begin : g_gate
      gate_state_e      state_q, state_d;
      logic [TMR_W-1:0] timer_q, timer_d;

      // Barrier sequencing.
      // An accept in either state (re)loads the full hold time.
      // The barrier closes only once the timer has expired with no new accept.
      always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
          GATE_CLOSED: begin
            if (gate_accept[gi]) begin
              state_d = GATE_OPEN;
              timer_d = RELOAD_V;
            end
          end
          GATE_OPEN: begin
            if (gate_accept[gi]) begin
              timer_d = RELOAD_V;
            end else if (timer_q == '0) begin
              state_d = GATE_CLOSED;
            end else begin
              timer_d = timer_q - TMR_W'(1);
            end
          end
          default: begin
            state_d = GATE_CLOSED;
            timer_d = '0;
          end
        endcase
      end

      // Barrier state and timer registers; reset closes the barrier at once.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q <= GATE_CLOSED;
          timer_q <= '0;
        end else begin
          state_q <= state_d;
          timer_q <= timer_d;
        end
      end

      assign gate_open[gi] = (state_q == GATE_OPEN);
    end
  endgenerate

  assign count           = count_q;
  assign full            = (count_q == CAP_V);
  assign empty           = (count_q == '0);
  assign entry_gate_open = gate_open[0];
  assign exit_gate_open  = gate_open[1];
  assign entry_denied    = entry_denied_q;
  assign exit_error      = exit_error_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl with CAPACITY=3 and OPEN_CYCLES=4.
// The stimulus process drives one input row per cycle on the falling edge.
// With each row it queues the hand-computed outputs expected after the next
// rising edge. A monitor pops and compares 1 ns after every rising edge.
module tb_parking_gate_ctrl;

  localparam int CAP = 3;
  localparam int OC  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_pulse = 1'b0;
  logic       exit_pulse = 1'b0;
  logic [1:0] count;
  logic       full, empty;
  logic       entry_gate_open, exit_gate_open;
  logic       entry_denied, exit_error;

  typedef struct {
    int         id;
    logic       en;
    logic       ex;
    logic [1:0] cnt;
    logic       eg;
    logic       xg;
    logic       den;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   row_id = 0;

  parking_gate_ctrl #(
    .CAPACITY   (CAP),
    .OPEN_CYCLES(OC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .entry_pulse    (entry_pulse),
    .exit_pulse     (exit_pulse),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .entry_gate_open(entry_gate_open),
    .exit_gate_open (exit_gate_open),
    .entry_denied   (entry_denied),
    .exit_error     (exit_error)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input int id, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s row %0d: got %0d, expected %0d", name, id, act, req);
  endtask

  // One stimulus row: drive on the falling edge and queue the expected outputs.
  task automatic cyc(input logic en, input logic ex, input logic [1:0] c,
                     input logic eg, input logic xg, input logic den, input logic err);
    exp_t e;
    @(negedge clk);
    entry_pulse = en;
    exit_pulse  = ex;
    e.id = row_id; e.en = en; e.ex = ex; e.cnt = c;
    e.eg = eg; e.xg = xg; e.den = den; e.err = err;
    row_id++;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [1:0] c, input logic eg, input logic xg);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, c, eg, xg, 1'b0, 1'b0);
  endtask

  // Monitor: compare every queued expectation just after the rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("row %0d in e=%0b x=%0b -> count=%0d full=%0b empty=%0b eg=%0b xg=%0b den=%0b err=%0b",
                 e.id, e.en, e.ex, count, full, empty, entry_gate_open, exit_gate_open,
                 entry_denied, exit_error);
        check1("count",        e.id, 8'(count),           8'(e.cnt));
        check1("full",         e.id, 8'(full),            8'(e.cnt == 2'(CAP)));
        check1("empty",        e.id, 8'(empty),           8'(e.cnt == 2'd0));
        check1("entry_gate",   e.id, 8'(entry_gate_open), 8'(e.eg));
        check1("exit_gate",    e.id, 8'(exit_gate_open),  8'(e.xg));
        check1("entry_denied", e.id, 8'(entry_denied),    8'(e.den));
        check1("exit_error",   e.id, 8'(exit_error),      8'(e.err));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stimulus
    // Reset state, sampled while reset is held.
    cyc(0, 0, 2'd0, 0, 0, 0, 0);
    cyc(0, 0, 2'd0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: three entries spaced 10 cycles apart; gate high 4 cycles per entry.
    cyc(1, 0, 2'd1, 1, 0, 0, 0); idle(3, 2'd1, 1, 0); idle(6, 2'd1, 0, 0);
    cyc(1, 0, 2'd2, 1, 0, 0, 0); idle(3, 2'd2, 1, 0); idle(6, 2'd2, 0, 0);
    cyc(1, 0, 2'd3, 1, 0, 0, 0); idle(3, 2'd3, 1, 0); idle(6, 2'd3, 0, 0);

    // 2: full lot, entry denied, including back-to-back denials.
    cyc(1, 0, 2'd3, 0, 0, 1, 0); idle(3, 2'd3, 0, 0);
    cyc(1, 0, 2'd3, 0, 0, 1, 0);
    cyc(1, 0, 2'd3, 0, 0, 1, 0);
    idle(1, 2'd3, 0, 0);

    // 3: full lot, simultaneous entry and exit; both gates open, count unchanged.
    cyc(1, 1, 2'd3, 1, 1, 0, 0); idle(3, 2'd3, 1, 1); idle(2, 2'd3, 0, 0);

    // Drain the lot with isolated exits.
    cyc(0, 1, 2'd2, 0, 1, 0, 0); idle(3, 2'd2, 0, 1); idle(1, 2'd2, 0, 0);
    cyc(0, 1, 2'd1, 0, 1, 0, 0); idle(3, 2'd1, 0, 1); idle(1, 2'd1, 0, 0);
    cyc(0, 1, 2'd0, 0, 1, 0, 0); idle(3, 2'd0, 0, 1); idle(1, 2'd0, 0, 0);

    // 4: exits on an empty lot, then simultaneous entry and exit on an empty lot.
    cyc(0, 1, 2'd0, 0, 0, 0, 1); idle(1, 2'd0, 0, 0);
    cyc(0, 1, 2'd0, 0, 0, 0, 1);
    cyc(0, 1, 2'd0, 0, 0, 0, 1);
    idle(1, 2'd0, 0, 0);
    cyc(1, 1, 2'd1, 1, 0, 0, 1); idle(3, 2'd1, 1, 0); idle(1, 2'd1, 0, 0);

    // 5: entry at t=0 and retrigger at t=3; gate high for 7 cycles, count +2.
    cyc(1, 0, 2'd2, 1, 0, 0, 0);
    idle(2, 2'd2, 1, 0);
    cyc(1, 0, 2'd3, 1, 0, 0, 0);
    idle(3, 2'd3, 1, 0);
    idle(1, 2'd3, 0, 0);

    // 6: count=2 with both gates open, then an asynchronous reset between edges.
    cyc(1, 1, 2'd3, 1, 1, 0, 0);
    cyc(0, 1, 2'd2, 1, 1, 0, 0);
    @(negedge clk);
    entry_pulse = 1'b0;
    exit_pulse  = 1'b0;
    #2 reset = 1'b1;
    #1;
    $display("async reset mid-cycle -> count=%0d full=%0b empty=%0b eg=%0b xg=%0b den=%0b err=%0b",
             count, full, empty, entry_gate_open, exit_gate_open, entry_denied, exit_error);
    check1("async_count",      -1, 8'(count),           8'd0);
    check1("async_empty",      -1, 8'(empty),           8'd1);
    check1("async_full",       -1, 8'(full),            8'd0);
    check1("async_entry_gate", -1, 8'(entry_gate_open), 8'd0);
    check1("async_exit_gate",  -1, 8'(exit_gate_open),  8'd0);
    cyc(0, 0, 2'd0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 0, 2'd1, 1, 0, 0, 0); idle(3, 2'd1, 1, 0); idle(1, 2'd1, 0, 0);

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
